// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory-side signals for the two-port memory arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface mem_port_arbiter_if;
    logic        req0;
    logic [63:0] addr0;
    logic        req1;
    logic [63:0] addr1;
    logic [63:0] wdata1;
    logic        we1;
    logic        done0;
    logic        done1;
    logic        err0;
    logic        err1;
    logic [63:0] rdata;
    logic        sel;
    logic        mem_valid;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic [63:0] mem_rdata;

    modport slave (
        input  req0, addr0, req1, addr1, wdata1, we1, mem_ready, mem_rdata,
        output done0, done1, err0, err1, rdata, sel,
               mem_valid, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req0, addr0, req1, addr1, wdata1, we1, mem_ready, mem_rdata,
        input  done0, done1, err0, err1, rdata, sel,
               mem_valid, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 64-bit memory port between instruction fetch
// (port 0) and data load/store (port 1), with an optional BUSY timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam logic             TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic        last_r, last_s;
    logic        sel_r, sel_s;
    logic        mem_valid_r, mem_valid_s;
    logic [63:0] mem_addr_r, mem_addr_s;
    logic [63:0] mem_wdata_r, mem_wdata_s;
    logic        mem_we_r, mem_we_s;
    logic        done0_r, done0_s;
    logic        done1_r, done1_s;
    logic        err0_r, err0_s;
    logic        err1_r, err1_s;
    logic [63:0] rdata_r, rdata_s;

    // A requester whose done pulse is still out has not had a chance to drop req yet.
    logic elig0_s, elig1_s, grant0_s, grant1_s;
    assign elig0_s  = bus.req0 & ~done0_r;
    assign elig1_s  = bus.req1 & ~done1_r;
    assign grant0_s = elig0_s & (~elig1_s | last_r);
    assign grant1_s = elig1_s & (~elig0_s | ~last_r);

    // Next-state and next-output computation for the IDLE/BUSY controller.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        last_s      = last_r;
        sel_s       = sel_r;
        mem_valid_s = mem_valid_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_we_s    = mem_we_r;
        done0_s     = 1'b0;
        done1_s     = 1'b0;
        err0_s      = 1'b0;
        err1_s      = 1'b0;
        rdata_s     = rdata_r;

        case (state_r)
            ST_IDLE: begin
                mem_valid_s = 1'b0;
                if (grant0_s) begin
                    sel_s       = 1'b0;
                    last_s      = 1'b0;
                    mem_addr_s  = bus.addr0;
                    mem_wdata_s = 64'h0;
                    mem_we_s    = 1'b0;
                    mem_valid_s = 1'b1;
                    cnt_s       = {CNT_W{1'b0}};
                    state_s     = ST_BUSY;
                end else if (grant1_s) begin
                    sel_s       = 1'b1;
                    last_s      = 1'b1;
                    mem_addr_s  = bus.addr1;
                    mem_wdata_s = bus.wdata1;
                    mem_we_s    = bus.we1;
                    mem_valid_s = 1'b1;
                    cnt_s       = {CNT_W{1'b0}};
                    state_s     = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // Completion takes priority over a timeout landing on the same edge.
                if (bus.mem_ready) begin
                    rdata_s     = bus.mem_rdata;
                    done0_s     = ~sel_r;
                    done1_s     = sel_r;
                    mem_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else if (TIMEOUT_EN && (cnt_r == CNT_LAST)) begin
                    rdata_s     = 64'h0;
                    done0_s     = ~sel_r;
                    done1_s     = sel_r;
                    err0_s      = ~sel_r;
                    err1_s      = sel_r;
                    mem_valid_s = 1'b0;
                    state_s     = ST_IDLE;
                end else if (cnt_r != CNT_MAX) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                mem_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset parks in IDLE with port 0 favoured next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            last_r      <= 1'b1;
            sel_r       <= 1'b0;
            mem_valid_r <= 1'b0;
            mem_addr_r  <= 64'h0;
            mem_wdata_r <= 64'h0;
            mem_we_r    <= 1'b0;
            done0_r     <= 1'b0;
            done1_r     <= 1'b0;
            err0_r      <= 1'b0;
            err1_r      <= 1'b0;
            rdata_r     <= 64'h0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            last_r      <= last_s;
            sel_r       <= sel_s;
            mem_valid_r <= mem_valid_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_we_r    <= mem_we_s;
            done0_r     <= done0_s;
            done1_r     <= done1_s;
            err0_r      <= err0_s;
            err1_r      <= err1_s;
            rdata_r     <= rdata_s;
        end
    end

    assign bus.done0     = done0_r;
    assign bus.done1     = done1_r;
    assign bus.err0      = err0_r;
    assign bus.err1      = err1_r;
    assign bus.rdata     = rdata_r;
    assign bus.sel       = sel_r;
    assign bus.mem_valid = mem_valid_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter built with a 4-cycle timeout.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_valid"}, {63'h0, bus.mem_valid}, 64'h0);
        chk({tag, "_sel"},   {63'h0, bus.sel},       64'h0);
        chk({tag, "_addr"},  bus.mem_addr,           64'h0);
        chk({tag, "_wdata"}, bus.mem_wdata,          64'h0);
        chk({tag, "_we"},    {63'h0, bus.mem_we},    64'h0);
        chk({tag, "_done"},  {62'h0, bus.done1, bus.done0}, 64'h0);
        chk({tag, "_err"},   {62'h0, bus.err1, bus.err0},   64'h0);
        chk({tag, "_rdata"}, bus.rdata,              64'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.req0 = 1'b0; bus.addr0 = 64'h0;
        bus.req1 = 1'b0; bus.addr1 = 64'h0; bus.wdata1 = 64'h0; bus.we1 = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = 64'h0;
        tick();
        tick();
        chk_idle_zero("reset");
        reset = 1'b0;

        // Single port-0 read, memory answers after two waiting cycles.
        bus.req0 = 1'b1; bus.addr0 = 64'h1000;
        tick();
        chk("t1_valid", {63'h0, bus.mem_valid}, 64'h1);
        chk("t1_addr",  bus.mem_addr, 64'h1000);
        chk("t1_sel",   {63'h0, bus.sel}, 64'h0);
        tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'hDEADBEEF;
        tick();
        chk("t1_done0", {63'h0, bus.done0}, 64'h1);
        chk("t1_err0",  {63'h0, bus.err0},  64'h0);
        chk("t1_rdata", bus.rdata, 64'hDEADBEEF);
        chk("t1_vlow",  {63'h0, bus.mem_valid}, 64'h0);
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        tick();
        chk("t1_pulse", {63'h0, bus.done0}, 64'h0);
        chk("t1_rhold", bus.rdata, 64'hDEADBEEF);

        // Simultaneous requests after reset, zero-wait memory: strict alternation.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr1 = 64'h3000; bus.we1 = 1'b0;
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'h11;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t2_g0_sel",   {63'h0, bus.sel}, 64'h0);
            chk("t2_g0_addr",  bus.mem_addr, 64'h1000);
            tick();
            chk("t2_done0",    {63'h0, bus.done0}, 64'h1);
            tick();
            chk("t2_g1_sel",   {63'h0, bus.sel}, 64'h1);
            chk("t2_g1_valid", {63'h0, bus.mem_valid}, 64'h1);
            chk("t2_g1_we",    {63'h0, bus.mem_we}, 64'h0);
            chk("t2_g1_addr",  bus.mem_addr, 64'h3000);
            tick();
            chk("t2_done1",    {63'h0, bus.done1}, 64'h1);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0;
        tick();
        chk("t2_idle", {63'h0, bus.mem_valid}, 64'h0);

        // Port-1 write; address change while BUSY must not leak through.
        bus.req1 = 1'b1; bus.addr1 = 64'h2000; bus.wdata1 = 64'h55AA; bus.we1 = 1'b1;
        tick();
        chk("t3_sel",   {63'h0, bus.sel}, 64'h1);
        chk("t3_we",    {63'h0, bus.mem_we}, 64'h1);
        chk("t3_wdata", bus.mem_wdata, 64'h55AA);
        chk("t3_addr",  bus.mem_addr, 64'h2000);
        bus.addr1 = 64'h9999;
        tick();
        chk("t3_hold",  bus.mem_addr, 64'h2000);
        chk("t3_valid", {63'h0, bus.mem_valid}, 64'h1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'h77;
        tick();
        chk("t3_done1", {63'h0, bus.done1}, 64'h1);
        chk("t3_err1",  {63'h0, bus.err1}, 64'h0);
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // Timeout on port 0 with port 1 pending.
        bus.req0 = 1'b1; bus.addr0 = 64'h4000;
        bus.req1 = 1'b1; bus.addr1 = 64'h5000; bus.wdata1 = 64'h0;
        tick();
        chk("t4_sel0", {63'h0, bus.sel}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_valid", {63'h0, bus.mem_valid}, 64'h1);
            tick();
        end
        chk("t4_vlow",  {63'h0, bus.mem_valid}, 64'h0);
        chk("t4_done0", {63'h0, bus.done0}, 64'h1);
        chk("t4_err0",  {63'h0, bus.err0},  64'h1);
        chk("t4_rdata", bus.rdata, 64'h0);
        bus.req0 = 1'b0;
        tick();
        chk("t4_err0_pulse", {63'h0, bus.err0}, 64'h0);
        chk("t4_sel1",  {63'h0, bus.sel}, 64'h1);
        chk("t4_addr1", bus.mem_addr, 64'h5000);

        // Ready arriving exactly on the timeout edge wins.
        tick();
        tick();
        tick();
        chk("t5_valid", {63'h0, bus.mem_valid}, 64'h1);
        bus.mem_ready = 1'b1; bus.mem_rdata = 64'hABCD;
        tick();
        chk("t5_done1", {63'h0, bus.done1}, 64'h1);
        chk("t5_err1",  {63'h0, bus.err1}, 64'h0);
        chk("t5_rdata", bus.rdata, 64'hABCD);
        bus.req1 = 1'b0; bus.mem_ready = 1'b0;
        tick();

        // Reset while BUSY after a port-0 grant; port 0 must still win afterwards.
        bus.req0 = 1'b1; bus.addr0 = 64'h6000;
        bus.req1 = 1'b1; bus.addr1 = 64'h7000;
        tick();
        chk("t6_sel0", {63'h0, bus.sel}, 64'h0);
        tick();
        reset = 1'b1;
        tick();
        chk_idle_zero("t6_rst");
        reset = 1'b0;
        tick();
        chk("t6_regrant_sel", {63'h0, bus.sel}, 64'h0);
        chk("t6_regrant_addr", bus.mem_addr, 64'h6000);
        chk("t6_regrant_valid", {63'h0, bus.mem_valid}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
